// File: rtl/qif_neuron_scheduler.sv
// qif_neuron_scheduler: time-multiplexes one QIF update datapath across NUM_NEURONS membrane/current slots
module qif_neuron_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int VW = 8,
  parameter int IW = 8,
  parameter int V_REST = 0,
  parameter int V_RESET = -16,
  localparam int AW = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [IW-1:0]          cfg_data,
  output logic                   dp_req,
  output logic [VW-1:0]          dp_v,
  output logic [IW-1:0]          dp_i,
  input  logic                   dp_ack,
  input  logic [VW-1:0]          dp_v_next,
  input  logic                   dp_spike,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic                   sweep_done,
  output logic                   busy,
  output logic                   overrun,
  output logic [7:0]             spike_cnt
);
  localparam logic [VW-1:0] vrest = VW'(V_REST);
  localparam logic [VW-1:0] vrst = VW'(V_RESET);
  typedef enum logic [1:0] {IDLE, ISSUE, WB, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] slot, slot_nx;
  logic [VW-1:0] v_mem [NUM_NEURONS];
  logic [IW-1:0] i_mem [NUM_NEURONS];
  logic [VW-1:0] res_v;
  logic res_spike, last;
  logic [NUM_NEURONS-1:0] spike_acc;
  assign last = slot == AW'(NUM_NEURONS - 1);
  assign slot_nx = slot + 1'b1;
  assign dp_req = state == ISSUE;
  assign sweep_done = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)  ? (tick ? ISSUE : IDLE) :
               (state == ISSUE) ? (dp_ack ? WB : ISSUE) :
               (state == WB)    ? (last ? DONE : ISSUE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      dp_v <= '0;
      dp_i <= '0;
      res_v <= '0;
      res_spike <= 1'b0;
      spike_acc <= '0;
      spike_vec <= '0;
      overrun <= 1'b0;
      spike_cnt <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_mem[n] <= vrest;
        i_mem[n] <= '0;
      end
    end else begin
      if (cfg_we) i_mem[cfg_addr] <= cfg_data;
      if (tick && state != IDLE) overrun <= 1'b1;
      if (tick && state == IDLE) begin
        slot <= '0;
        dp_v <= v_mem[0];
        dp_i <= i_mem[0];
      end
      if (state == ISSUE && dp_ack) begin
        res_v <= dp_v_next;
        res_spike <= dp_spike;
      end
      if (state == WB) begin
        v_mem[slot] <= res_spike ? vrst : res_v;
        spike_acc[slot] <= res_spike;
        spike_cnt <= spike_cnt + 8'(res_spike && spike_cnt != 8'hFF);
        // last slot's flag bypasses spike_acc so the whole vector lands at once
        if (last) spike_vec <= {res_spike, spike_acc[NUM_NEURONS-2:0]};
        else begin
          slot <= slot_nx;
          dp_v <= v_mem[slot_nx];
          dp_i <= i_mem[slot_nx];
        end
      end
    end
  end
endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// tb_qif_neuron_scheduler: scoreboard bench with a behavioural QIF datapath responder
module tb_qif_neuron_scheduler;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, cfg_we = 1'b0, dp_ack = 1'b0, dp_spike = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0, dp_v_next = '0;
  logic dp_req, sweep_done, busy, overrun;
  logic [7:0] dp_v, dp_i, spike_cnt;
  logic [3:0] spike_vec;
  always #5 clk = ~clk;
  qif_neuron_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .dp_req(dp_req), .dp_v(dp_v), .dp_i(dp_i), .dp_ack(dp_ack), .dp_v_next(dp_v_next),
    .dp_spike(dp_spike), .spike_vec(spike_vec), .sweep_done(sweep_done), .busy(busy),
    .overrun(overrun), .spike_cnt(spike_cnt)
  );
  typedef struct {logic [3:0] sv; logic [7:0] cnt; int lat;} sw_t;
  sw_t sw_q[$];
  sw_t e;
  logic [15:0] op_q[$];
  logic [15:0] cur = '0;
  int cmp = 0, errs = 0, cyc = 0, tick_cyc = 0, waits = 0, wcnt = 0, sweeps = 0, sum = 0, s0 = 0;
  bit junk = 1'b0;
  int ref_v[4], ref_i[4];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // datapath model: v_next = v + i, spike at >= 64, ack after `waits` stall cycles
  always @(posedge clk) begin
    #1;
    dp_ack = 1'b0;
    dp_spike = 1'b0;
    dp_v_next = '0;
    if (dp_req) begin
      if (wcnt == 0) begin
        if (op_q.size() == 0) begin
          cmp++;
          errs++;
          $display("FAIL unexpected_issue: got dp_req=1 expected no issue (cycle %0d)", cyc);
          cur = {dp_v, dp_i};
        end else cur = op_q.pop_front();
      end
      chk("dp_v", $signed(dp_v), $signed(cur[15:8]));
      chk("dp_i", $signed(dp_i), $signed(cur[7:0]));
      if (wcnt == waits) begin
        sum = $signed(cur[15:8]) + $signed(cur[7:0]);
        dp_ack = 1'b1;
        dp_spike = sum >= 64;
        dp_v_next = sum[7:0];
        wcnt = 0;
      end else wcnt++;
    end else if (junk) begin
      dp_ack = 1'b1;
      dp_spike = 1'b1;
      dp_v_next = 8'h55;
    end
  end
  always @(posedge clk) begin
    #1;
    if (sweep_done) begin
      sweeps++;
      if (sw_q.size() == 0) begin
        cmp++;
        errs++;
        $display("FAIL unexpected_sweep_done: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e = sw_q.pop_front();
        chk("spike_vec", spike_vec, e.sv);
        chk("spike_cnt", spike_cnt, e.cnt);
        chk("latency", cyc - tick_cyc, e.lat);
      end
    end
  end
  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      ref_v[s] = 0;
      ref_i[s] = 0;
    end
  endtask
  task automatic push_ops();
    for (int s = 0; s < 4; s++) begin
      int r;
      op_q.push_back({8'(ref_v[s]), 8'(ref_i[s])});
      r = ref_v[s] + ref_i[s];
      ref_v[s] = (r >= 64) ? -16 : r;
    end
  endtask
  task automatic wr(input int a, input int d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 2'(a);
    cfg_data = 8'(d);
    ref_i[a] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    op_q.delete();
    sw_q.delete();
    wcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  task automatic wait_idle();
    int n = 0;
    while (sw_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sw_q.size() != 0) begin
      cmp++;
      errs++;
      $display("FAIL sweep_timeout: got no sweep_done expected one within 200 cycles");
      sw_q.delete();
    end
    @(negedge clk);
  endtask
  task automatic do_sweep(input logic [3:0] sv, input int cnt, input int lat,
                          input bit cw = 1'b0, input int ca = 0, input int cd = 0, input bit dbl = 1'b0);
    sw_t x;
    x.sv = sv;
    x.cnt = 8'(cnt);
    x.lat = lat;
    sw_q.push_back(x);
    push_ops();
    @(negedge clk);
    tick = 1'b1;
    tick_cyc = cyc;
    cfg_we = cw;
    cfg_addr = 2'(ca);
    cfg_data = 8'(cd);
    if (cw) ref_i[ca] = cd;
    @(negedge clk);
    tick = 1'b0;
    cfg_we = 1'b0;
    if (dbl) begin
      repeat (1) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
    wait_idle();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_dp_req", dp_req, 0);
    chk("rst_dp_v", dp_v, 0);
    chk("rst_dp_i", dp_i, 0);
    chk("rst_spike_vec", spike_vec, 0);
    chk("rst_sweep_done", sweep_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_spike_cnt", spike_cnt, 0);
    rst = 1'b0;
    wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 70);
    do_sweep(4'b1000, 1, 9);
    do_sweep(4'b0000, 1, 9);
    do_sweep(4'b1100, 3, 9);
    do_sweep(4'b0010, 4, 9);
    chk("overrun_clean", overrun, 0);
    do_reset();
    waits = 3;
    junk = 1'b1;
    wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 70);
    do_sweep(4'b1000, 1, 21);
    do_sweep(4'b0000, 1, 21);
    @(negedge clk);
    waits = 0;
    junk = 1'b0;
    do_sweep(4'b1100, 3, 9, 1'b1, 0, 50);
    do_sweep(4'b0011, 5, 9);
    chk("overrun_before", overrun, 0);
    s0 = sweeps;
    do_sweep(4'b1000, 6, 9, 1'b0, 0, 0, 1'b1);
    repeat (20) @(negedge clk);
    chk("overrun_set", overrun, 1);
    chk("single_sweep", sweeps - s0, 1);
    do_sweep(4'b0101, 8, 9);
    chk("overrun_sticky", overrun, 1);
    do_reset();
    wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 70);
    do_sweep(4'b1000, 1, 9);
    push_ops();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_dp_req", dp_req, 1);
    rst = 1'b1;
    op_q.delete();
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_dp_req_low", dp_req, 0);
    chk("mid_spike_vec", spike_vec, 0);
    chk("mid_spike_cnt", spike_cnt, 0);
    rst = 1'b0;
    model_reset();
    do_sweep(4'b0000, 0, 9);
    do_reset();
    wr(0, 127);
    for (int k = 1; k <= 300; k++) do_sweep(4'b0001, (k > 255) ? 255 : k, 9);
    chk("sat_spike_cnt", spike_cnt, 255);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
